// File: rtl/eth_sw_out_arb.sv
// ---------------------------------------------------------------------------
// eth_sw_out_arb_fifo
//   Word FIFO for one ingress port of the egress arbiter. Each entry is
//   {sop, eop, data}. Besides the head word it exposes the sop flag of the
//   word behind the head. The arbiter uses that flag to re-arbitrate in the
//   same cycle that it pops an eop, without waiting for the FIFO to advance.
//
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     push, wdata  write request and word; a push while full is dropped
//     pop          remove the head word (ignored while empty)
//     head         current head word
//     empty        no words stored
//     has_second   at least two words stored
//     second_sop   sop flag of the word behind the head (valid with has_second)
//     stall        registered: occupancy after this edge >= DEPTH-STALL_MARGIN
//     ovfl         sticky: a word was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module eth_sw_out_arb_fifo #(
  parameter int WORD_W       = 34,
  parameter int DEPTH        = 16,
  parameter int STALL_MARGIN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic              empty,
  output logic              has_second,
  output logic              second_sop,
  output logic              stall,
  output logic              ovfl
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - STALL_MARGIN);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              full;
  logic              wr_en;
  logic              rd_en;
  logic [WORD_W-1:0] second;

  // Full is judged on the occupancy before this edge, so a full FIFO that
  // pops in the same cycle still drops the incoming word.
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign has_second = (count > CNT_W'(1));
  assign wr_en      = push & ~full;
  assign rd_en      = pop & ~empty;

  assign head       = mem[rd_ptr];
  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign second     = mem[rd_ptr + ADDR_W'(1)];
  assign second_sop = second[WORD_W-1];

  // NOTE: every variable gets a default at the top of the always_comb, so
  // no path through the case statement can leave it unassigned (no latch).
  always_comb begin
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff block samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      stall  <= 1'b0;
      ovfl   <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      count <= count_nxt;
      stall <= (count_nxt >= STALL_CNT);
      if (push && full) ovfl <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset. Emptiness is tracked only by the
  // pointers and the count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// ---------------------------------------------------------------------------
// eth_sw_out_arb
//   Packet-granular round-robin arbiter. It merges two ingress streams (A, B)
//   onto one egress port. Whole packets (sop..eop) are never interleaved.
//   Fragments whose head word lacks sop are purged while the arbiter is idle.
//
//   Ports:
//     clk, reset                              clock, sync active-high reset
//     inDataX/inSopX/inEopX/inValidX          ingress word for port X (A/B)
//     portXStall                              advisory backpressure to source X
//     ovflX                                   sticky overflow flag for port X
//     outData/outSop/outEop/outValid          registered egress word
//     outStall                                egress backpressure (next pop)
//     grantA / grantB                         arbiter is sending A / B
// ---------------------------------------------------------------------------
module eth_sw_out_arb #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int STALL_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] inDataA,
  input  logic                  inSopA,
  input  logic                  inEopA,
  input  logic                  inValidA,
  output logic                  portAStall,
  output logic                  ovflA,
  input  logic [DATA_WIDTH-1:0] inDataB,
  input  logic                  inSopB,
  input  logic                  inEopB,
  input  logic                  inValidB,
  output logic                  portBStall,
  output logic                  ovflB,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outSop,
  output logic                  outEop,
  output logic                  outValid,
  input  logic                  outStall,
  output logic                  grantA,
  output logic                  grantB
);

  localparam int WORD_W  = DATA_WIDTH + 2;
  localparam int SOP_BIT = DATA_WIDTH + 1;
  localparam int EOP_BIT = DATA_WIDTH;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND_A = 2'd1;
  localparam logic [1:0] ST_SEND_B = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  // 1 = B was granted most recently, so A wins the next tie.
  logic              last_grant_b;
  logic              last_grant_b_nxt;

  logic [WORD_W-1:0] head_a;
  logic [WORD_W-1:0] head_b;
  logic              empty_a;
  logic              empty_b;
  logic              has_second_a;
  logic              has_second_b;
  logic              second_sop_a;
  logic              second_sop_b;
  logic              elig_a;
  logic              elig_b;
  logic              elig_a_after;
  logic              elig_b_after;
  logic              purge_a;
  logic              purge_b;
  logic              fwd_a;
  logic              fwd_b;
  logic              pop_a;
  logic              pop_b;

  eth_sw_out_arb_fifo #(
    .WORD_W       (WORD_W),
    .DEPTH        (FIFO_DEPTH),
    .STALL_MARGIN (STALL_MARGIN)
  ) u_fifo_a (
    .clk        (clk),
    .reset      (reset),
    .push       (inValidA),
    .wdata      ({inSopA, inEopA, inDataA}),
    .pop        (pop_a),
    .head       (head_a),
    .empty      (empty_a),
    .has_second (has_second_a),
    .second_sop (second_sop_a),
    .stall      (portAStall),
    .ovfl       (ovflA)
  );

  eth_sw_out_arb_fifo #(
    .WORD_W       (WORD_W),
    .DEPTH        (FIFO_DEPTH),
    .STALL_MARGIN (STALL_MARGIN)
  ) u_fifo_b (
    .clk        (clk),
    .reset      (reset),
    .push       (inValidB),
    .wdata      ({inSopB, inEopB, inDataB}),
    .pop        (pop_b),
    .head       (head_b),
    .empty      (empty_b),
    .has_second (has_second_b),
    .second_sop (second_sop_b),
    .stall      (portBStall),
    .ovfl       (ovflB)
  );

  // A port may start a packet only when its head word carries sop.
  assign elig_a = ~empty_a & head_a[SOP_BIT];
  assign elig_b = ~empty_b & head_b[SOP_BIT];

  // Eligibility of a port once its head (an eop) has been popped: it depends
  // on the word behind the head, not on anything pushed at this edge.
  assign elig_a_after = has_second_a & second_sop_a;
  assign elig_b_after = has_second_b & second_sop_b;

  always_comb begin
    state_nxt        = state;
    last_grant_b_nxt = last_grant_b;
    purge_a          = 1'b0;
    purge_b          = 1'b0;
    fwd_a            = 1'b0;
    fwd_b            = 1'b0;

    case (state)
      ST_IDLE: begin
        // Orphan fragments are drained one word per cycle per port.
        purge_a = ~empty_a & ~head_a[SOP_BIT];
        purge_b = ~empty_b & ~head_b[SOP_BIT];
        if (elig_a && elig_b) begin
          state_nxt = last_grant_b ? ST_SEND_A : ST_SEND_B;
        end else if (elig_a) begin
          state_nxt = ST_SEND_A;
        end else if (elig_b) begin
          state_nxt = ST_SEND_B;
        end
      end

      ST_SEND_A: begin
        // The grant is held through an empty FIFO: a starved packet stalls
        // the output rather than letting the other port interleave.
        fwd_a = ~empty_a & ~outStall;
        if (fwd_a && head_a[EOP_BIT]) begin
          last_grant_b_nxt = 1'b0;
          if (elig_b) begin
            state_nxt = ST_SEND_B;
          end else if (elig_a_after) begin
            state_nxt = ST_SEND_A;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_SEND_B: begin
        fwd_b = ~empty_b & ~outStall;
        if (fwd_b && head_b[EOP_BIT]) begin
          last_grant_b_nxt = 1'b1;
          if (elig_a) begin
            state_nxt = ST_SEND_A;
          end else if (elig_b_after) begin
            state_nxt = ST_SEND_B;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pop_a = purge_a | fwd_a;
  assign pop_b = purge_b | fwd_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      last_grant_b <= 1'b1;
    end else begin
      state        <= state_nxt;
      last_grant_b <= last_grant_b_nxt;
    end
  end

  // The egress register loads only on a forwarding pop. Otherwise it keeps
  // the last word and drops outValid, so downstream sees no glitching data.
  always_ff @(posedge clk) begin
    if (reset) begin
      outData  <= '0;
      outSop   <= 1'b0;
      outEop   <= 1'b0;
      outValid <= 1'b0;
    end else begin
      outValid <= fwd_a | fwd_b;
      if (fwd_a) begin
        outData <= head_a[DATA_WIDTH-1:0];
        outSop  <= head_a[SOP_BIT];
        outEop  <= head_a[EOP_BIT];
      end else if (fwd_b) begin
        outData <= head_b[DATA_WIDTH-1:0];
        outSop  <= head_b[SOP_BIT];
        outEop  <= head_b[EOP_BIT];
      end
    end
  end

  assign grantA = (state == ST_SEND_A);
  assign grantB = (state == ST_SEND_B);

endmodule

// File: tb/tb_eth_sw_out_arb.sv
`timescale 1ns/1ps
module tb_eth_sw_out_arb;

  localparam int DW = 32;
  localparam int FD = 16;
  localparam int SM = 4;

  localparam int M_IDLE = 0;
  localparam int M_A    = 1;
  localparam int M_B    = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } word_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] inDataA, inDataB;
  logic          inSopA, inEopA, inValidA;
  logic          inSopB, inEopB, inValidB;
  logic          portAStall, portBStall, ovflA, ovflB;
  logic [DW-1:0] outData;
  logic          outSop, outEop, outValid, outStall;
  logic          grantA, grantB;

  always #5 clk = ~clk;

  eth_sw_out_arb #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (FD),
    .STALL_MARGIN (SM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inDataA    (inDataA),
    .inSopA     (inSopA),
    .inEopA     (inEopA),
    .inValidA   (inValidA),
    .portAStall (portAStall),
    .ovflA      (ovflA),
    .inDataB    (inDataB),
    .inSopB     (inSopB),
    .inEopB     (inEopB),
    .inValidB   (inValidB),
    .portBStall (portBStall),
    .ovflB      (ovflB),
    .outData    (outData),
    .outSop     (outSop),
    .outEop     (outEop),
    .outValid   (outValid),
    .outStall   (outStall),
    .grantA     (grantA),
    .grantB     (grantB)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural model: two packet queues, who is being served, who was last.
  word_t         qa[$];
  word_t         qb[$];
  int            m_state  = M_IDLE;
  bit            m_last_b = 1'b1;
  logic          e_valid = 1'b0, e_sop = 1'b0, e_eop = 1'b0;
  logic [DW-1:0] e_data = '0;
  logic          e_ga = 1'b0, e_gb = 1'b0, e_sa = 1'b0, e_sb = 1'b0;
  logic          e_oa = 1'b0, e_ob = 1'b0;

  obs_t          out_log[$];
  logic [DW-1:0] exp_words[$];

  int rem [2];
  int seq [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [40:0] act_vec();
    return {outValid, outSop, outEop, outData, grantA, grantB,
            portAStall, portBStall, ovflA, ovflB};
  endfunction

  function automatic logic [40:0] exp_vec();
    return {e_valid, e_sop, e_eop, e_data, e_ga, e_gb, e_sa, e_sb, e_oa, e_ob};
  endfunction

  // One clock edge of the reference: decide pops from the queues as they
  // stand before the edge, then apply pops, then accept the new words.
  task automatic model_step();
    bit    pa, pb, fwd, ea, eb, full_a, full_b;
    word_t fw;
    word_t w;
    if (reset) begin
      qa.delete();
      qb.delete();
      m_state  = M_IDLE;
      m_last_b = 1'b1;
      e_valid = 0; e_sop = 0; e_eop = 0; e_data = '0;
      e_ga = 0; e_gb = 0; e_sa = 0; e_sb = 0; e_oa = 0; e_ob = 0;
      return;
    end
    pa = 0; pb = 0; fwd = 0; fw = '0;
    full_a = (qa.size() == FD);
    full_b = (qb.size() == FD);
    ea = (qa.size() > 0) && qa[0].sop;
    eb = (qb.size() > 0) && qb[0].sop;
    if (m_state == M_IDLE) begin
      pa = (qa.size() > 0) && !qa[0].sop;
      pb = (qb.size() > 0) && !qb[0].sop;
      if (ea && eb) m_state = m_last_b ? M_A : M_B;
      else if (ea)  m_state = M_A;
      else if (eb)  m_state = M_B;
    end else if (m_state == M_A) begin
      if (qa.size() > 0 && !outStall) begin
        fwd = 1; fw = qa[0]; pa = 1;
        if (fw.eop) begin
          m_last_b = 1'b0;
          if (eb)                                 m_state = M_B;
          else if (qa.size() > 1 && qa[1].sop)    m_state = M_A;
          else                                    m_state = M_IDLE;
        end
      end
    end else begin
      if (qb.size() > 0 && !outStall) begin
        fwd = 1; fw = qb[0]; pb = 1;
        if (fw.eop) begin
          m_last_b = 1'b1;
          if (ea)                                 m_state = M_A;
          else if (qb.size() > 1 && qb[1].sop)    m_state = M_B;
          else                                    m_state = M_IDLE;
        end
      end
    end
    e_valid = fwd;
    if (fwd) begin
      e_data = fw.data; e_sop = fw.sop; e_eop = fw.eop;
    end
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (inValidA) begin
      if (full_a) e_oa = 1'b1;
      else begin
        w.data = inDataA; w.sop = inSopA; w.eop = inEopA;
        qa.push_back(w);
      end
    end
    if (inValidB) begin
      if (full_b) e_ob = 1'b1;
      else begin
        w.data = inDataB; w.sop = inSopB; w.eop = inEopB;
        qb.push_back(w);
      end
    end
    e_sa = (qa.size() >= FD - SM);
    e_sb = (qb.size() >= FD - SM);
    e_ga = (m_state == M_A);
    e_gb = (m_state == M_B);
  endtask

  // Compare process: model advances on the edge, DUT sampled 1 ns later.
  always @(posedge clk) begin
    obs_t o;
    cyc++;
    model_step();
    #1;
    check("cycle_outputs", 64'(act_vec()), 64'(exp_vec()));
    if (outValid === 1'b1) begin
      o.cyc = cyc; o.data = outData; o.sop = outSop; o.eop = outEop;
      out_log.push_back(o);
    end
  end

  task automatic drive(input bit va, input logic [DW-1:0] da, input bit sa, input bit ea,
                       input bit vb, input logic [DW-1:0] db, input bit sb, input bit eb);
    inValidA = va; inDataA = da; inSopA = sa; inEopA = ea;
    inValidB = vb; inDataB = db; inSopB = sb; inEopB = eb;
    @(negedge clk);
    inValidA = 1'b0;
    inValidB = 1'b0;
  endtask

  task automatic drive_a(input logic [DW-1:0] d, input bit s, input bit e);
    drive(1'b1, d, s, e, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drive_b(input logic [DW-1:0] d, input bit s, input bit e);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, d, s, e);
  endtask

  task automatic idle(input int n);
    inValidA = 1'b0;
    inValidB = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    inValidA = 1'b0; inValidB = 1'b0; outStall = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, 64'(out_log.size()), 64'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < out_log.size(); i++)
      check({name, "_word"}, 64'(out_log[i].data), 64'(exp_words[i]));
  endtask

  // Random source for one port: packets of 1..6 words, occasionally missing
  // sop or eop, mostly honouring the advisory stall.
  task automatic gen(input int p, input logic stall, output logic v, output word_t w);
    bit first;
    v = 1'b0;
    w = '0;
    if (stall && $urandom_range(0, 4) != 0) return;
    if ($urandom_range(0, 2) == 0) return;
    v = 1'b1;
    first = (rem[p] == 0);
    if (first) rem[p] = $urandom_range(1, 6);
    w.data = (32'(p + 1) << 28) | 32'(seq[p]);
    seq[p]++;
    w.sop = first && ($urandom_range(0, 9) != 0);
    w.eop = (rem[p] == 1) && ($urandom_range(0, 9) != 0);
    rem[p]--;
  endtask

  initial begin
    int    c0;
    logic  va, vb;
    word_t wa, wb;

    reset = 1'b1;
    inDataA = '0; inSopA = 0; inEopA = 0; inValidA = 0;
    inDataB = '0; inSopB = 0; inEopB = 0; inValidB = 0;
    outStall = 1'b0;
    rem[0] = 0; rem[1] = 0; seq[0] = 0; seq[1] = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(act_vec()), 64'd0);
    reset = 1'b0;

    // 1: single 4-word packet on A, B idle.
    out_log.delete();
    c0 = cyc + 1;
    drive_a(32'h11, 1, 0);
    drive_a(32'h12, 0, 0);
    drive_a(32'h13, 0, 0);
    drive_a(32'h14, 0, 1);
    idle(8);
    exp_words = '{32'h11, 32'h12, 32'h13, 32'h14};
    check_log("t1");
    if (out_log.size() == 4) begin
      check("t1_latency", 64'(out_log[0].cyc - c0), 64'd2);
      check("t1_sop_first", 64'(out_log[0].sop), 64'd1);
      check("t1_eop_last", 64'(out_log[3].eop), 64'd1);
      check("t1_back_to_back", 64'(out_log[3].cyc - out_log[0].cyc), 64'd3);
    end
    check("t1_idle_after", 64'({grantA, grantB}), 64'd0);

    // 2: A and B each send two 3-word packets starting in the same cycle.
    reset_dut();
    out_log.delete();
    for (int p = 0; p < 2; p++)
      for (int w = 0; w < 3; w++)
        drive(1, 32'hA00 + 32'(p * 16 + w), w == 0, w == 2,
              1, 32'hB00 + 32'(p * 16 + w), w == 0, w == 2);
    idle(20);
    exp_words = '{32'hA00, 32'hA01, 32'hA02, 32'hB00, 32'hB01, 32'hB02,
                  32'hA10, 32'hA11, 32'hA12, 32'hB10, 32'hB11, 32'hB12};
    check_log("t2");
    if (out_log.size() == 12) begin
      check("t2_no_bubble", 64'(out_log[11].cyc - out_log[0].cyc), 64'd11);
      for (int i = 0; i < 12; i++)
        check("t2_framing", 64'({out_log[i].sop, out_log[i].eop}),
              64'({i % 3 == 0, i % 3 == 2}));
    end

    // 3: 5 cycles of egress stall in the middle of an 8-word B packet.
    reset_dut();
    out_log.delete();
    c0 = cyc + 1;
    for (int w = 0; w < 4; w++) drive_b(32'h300 + 32'(w), w == 0, 0);
    outStall = 1'b1;
    for (int w = 4; w < 8; w++) drive_b(32'h300 + 32'(w), 0, w == 7);
    idle(1);
    outStall = 1'b0;
    idle(12);
    exp_words.delete();
    for (int w = 0; w < 8; w++) exp_words.push_back(32'h300 + 32'(w));
    check_log("t3");
    if (out_log.size() == 8) begin
      check("t3_resume", 64'(out_log[2].cyc - c0), 64'd9);
      check("t3_span", 64'(out_log[7].cyc - out_log[0].cyc), 64'd12);
    end

    // 4: A streams 20 words into a stalled egress.
    reset_dut();
    outStall = 1'b1;
    out_log.delete();
    for (int i = 0; i < 20; i++) begin
      drive_a(32'h400 + 32'(i), i == 0, i == 19);
      if (i == 10) check("t4_stall_at_11", 64'(portAStall), 64'd0);
      if (i == 11) check("t4_stall_at_12", 64'(portAStall), 64'd1);
      if (i == 15) check("t4_ovfl_at_16", 64'(ovflA), 64'd0);
      if (i == 16) check("t4_ovfl_at_17", 64'(ovflA), 64'd1);
    end
    idle(3);
    outStall = 1'b0;
    idle(25);
    exp_words.delete();
    for (int i = 0; i < 16; i++) exp_words.push_back(32'h400 + 32'(i));
    check_log("t4");
    check("t4_ovfl_sticky", 64'(ovflA), 64'd1);
    check("t4_stall_drained", 64'(portAStall), 64'd0);

    // 5: headless fragment followed by a good packet.
    reset_dut();
    out_log.delete();
    drive_a(32'h500, 0, 0);
    drive_a(32'h501, 0, 1);
    drive_a(32'h51, 1, 0);
    drive_a(32'h52, 0, 0);
    drive_a(32'h53, 0, 1);
    idle(10);
    exp_words = '{32'h51, 32'h52, 32'h53};
    check_log("t5");
    if (out_log.size() == 3) check("t5_sop", 64'(out_log[0].sop), 64'd1);

    // 6: reset in the middle of an A packet, then B arrives.
    reset_dut();
    drive_a(32'h61, 1, 0);
    drive_a(32'h62, 0, 0);
    idle(3);
    reset = 1'b1;
    @(negedge clk);
    check("t6_reset_outputs", 64'(act_vec()), 64'd0);
    reset = 1'b0;
    out_log.delete();
    c0 = cyc + 1;
    drive(1, 32'h63, 0, 0, 1, 32'h71, 1, 0);
    drive(1, 32'h64, 0, 1, 1, 32'h72, 0, 0);
    drive_b(32'h73, 0, 1);
    idle(10);
    exp_words = '{32'h71, 32'h72, 32'h73};
    check_log("t6");
    if (out_log.size() == 3) check("t6_latency", 64'(out_log[0].cyc - c0), 64'd2);

    // Random traffic against the model.
    reset_dut();
    for (int k = 0; k < 4000; k++) begin
      gen(0, portAStall, va, wa);
      gen(1, portBStall, vb, wb);
      inValidA = va; inDataA = wa.data; inSopA = wa.sop; inEopA = wa.eop;
      inValidB = vb; inDataB = wb.data; inSopB = wb.sop; inEopB = wb.eop;
      outStall = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    outStall = 1'b0;
    idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
